// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: x - y, LSB first, one full-subtractor cell per clock.
// Optional signed overflow output is enabled with `define SERIAL_SUB_SIGNED_EN.
module serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SERIAL_SUB_SIGNED_EN
  output logic             equal,
  output logic             overflow
`else
  output logic             equal
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_sr_q, x_sr_d;
  logic [WIDTH-1:0] y_sr_q, y_sr_d;
  logic [WIDTH-2:0] res_sr_q, res_sr_d;  // final bit comes straight from the cell
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             equal_q, equal_d;
`ifdef SERIAL_SUB_SIGNED_EN
  logic             x_msb_q, x_msb_d;
  logic             y_msb_q, y_msb_d;
  logic             overflow_q, overflow_d;
`endif

  logic             a_bit, b_bit, d_bit, bout;
  logic [WIDTH-1:0] result;

  assign a_bit  = x_sr_q[0];
  assign b_bit  = y_sr_q[0];
  assign d_bit  = a_bit ^ b_bit ^ bin_q;
  assign bout   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
  assign result = {d_bit, res_sr_q};

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    x_sr_d   = x_sr_q;
    y_sr_d   = y_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    equal_d  = equal_q;
`ifdef SERIAL_SUB_SIGNED_EN
    x_msb_d    = x_msb_q;
    y_msb_d    = y_msb_q;
    overflow_d = overflow_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_sr_d  = x;
          y_sr_d  = y;
          cnt_d   = '0;
          bin_d   = 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
          x_msb_d = x[WIDTH-1];
          y_msb_d = y[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        x_sr_d   = x_sr_q >> 1;
        y_sr_d   = y_sr_q >> 1;
        res_sr_d = result[WIDTH-1:1];
        bin_d    = bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          diff_d   = result;
          borrow_d = bout;
          equal_d  = (result == '0);
`ifdef SERIAL_SUB_SIGNED_EN
          overflow_d = (x_msb_q != y_msb_q) && (result[WIDTH-1] != x_msb_q);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the shift registers are few flops, not a memory, so they are reset like everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_sr_q   <= '0;
      y_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      equal_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      x_msb_q    <= 1'b0;
      y_msb_q    <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_sr_q   <= x_sr_d;
      y_sr_q   <= y_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      equal_q  <= equal_d;
`ifdef SERIAL_SUB_SIGNED_EN
      x_msb_q    <= x_msb_d;
      y_msb_q    <= y_msb_d;
      overflow_q <= overflow_d;
`endif
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign equal  = equal_q;
`ifdef SERIAL_SUB_SIGNED_EN
  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=5); expected values hand-computed.
module tb_serial_subtractor;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             equal;
`ifdef SERIAL_SUB_SIGNED_EN
  logic             overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
`ifdef SERIAL_SUB_SIGNED_EN
    .equal  (equal),
    .overflow(overflow)
`else
    .equal  (equal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at the negedge right after the accepting edge; returns at the negedge inside the done cycle.
  task automatic wait_done(output int busy_cycles, output int done_cycle);
    busy_cycles = 0;
    done_cycle  = -1;
    for (int i = 1; i <= 20 && done_cycle < 0; i++) begin
      if (busy) busy_cycles++;
      if (done) done_cycle = i;
      if (done_cycle < 0) @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int busy_cycles, output int done_cycle);
    @(negedge clk);
    x = a;
    y = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(busy_cycles, done_cycle);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] exp_diff,
                              input logic exp_borrow, input logic exp_equal);
    check({tag, ".diff"},   32'(diff),   32'(exp_diff));
    check({tag, ".borrow"}, 32'(borrow), 32'(exp_borrow));
    check({tag, ".equal"},  32'(equal),  32'(exp_equal));
  endtask

  int bc, dc, done_hits;

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst.busy",   32'(busy),   32'd0);
    check("rst.done",   32'(done),   32'd0);
    check_result("rst", 5'b00000, 1'b0, 1'b0);
`ifdef SERIAL_SUB_SIGNED_EN
    check("rst.overflow", 32'(overflow), 32'd0);
`endif

    // Latency: busy for WIDTH cycles, done in cycle WIDTH+1 after the accepting edge
    run_op(5'b00001, 5'b00000, bc, dc);
    check("lat.busy_cycles", 32'(bc), 32'd5);
    check("lat.done_cycle",  32'(dc), 32'd6);
    check_result("lat", 5'b00001, 1'b0, 1'b0);
    @(negedge clk);
    check("lat.done_pulse_width", 32'(done), 32'd0);

    // Equality and a borrowing subtract
    run_op(5'b01100, 5'b01100, bc, dc);
    check("eq.done_cycle", 32'(dc), 32'd6);
    check_result("eq", 5'b00000, 1'b0, 1'b1);
    run_op(5'b00001, 5'b00100, bc, dc);
    check("neg.done_cycle", 32'(dc), 32'd6);
    check_result("neg", 5'b11101, 1'b1, 1'b0);
`ifdef SERIAL_SUB_SIGNED_EN
    check("neg.overflow", 32'(overflow), 32'd0);
`endif

    // Result hold for 10 idle cycles
    done_hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    check("hold.done_hits", 32'(done_hits), 32'd0);
    check_result("hold", 5'b11101, 1'b1, 1'b0);

    // Inputs ignored during RUN; held start relaunches only after DONE->IDLE
    @(negedge clk);
    x = 5'b10101;
    y = 5'b10100;
    start = 1'b1;
    @(negedge clk);
    x = 5'b11111;
    wait_done(bc, dc);
    check("ign.done_cycle", 32'(dc), 32'd6);
    check_result("ign", 5'b00001, 1'b0, 1'b0);
    @(negedge clk);
    check("ign.idle_busy", 32'(busy), 32'd0);
    check("ign.idle_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("ign.restart_busy", 32'(busy), 32'd1);
    wait_done(bc, dc);
    check("ign2.done_cycle", 32'(dc), 32'd6);
    check_result("ign2", 5'b01011, 1'b0, 1'b0);

    // Boundary: 0 - all-ones
    run_op(5'b00000, 5'b11111, bc, dc);
    check_result("zero_minus_ones", 5'b00001, 1'b1, 1'b0);

    // Asynchronous reset in the 3rd RUN cycle
    @(negedge clk);
    x = 5'b00111;
    y = 5'b00001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.done", 32'(done), 32'd0);
    check("mid.diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_hits++;
    end
    check("mid.no_done", 32'(done_hits), 32'd0);
    run_op(5'b11100, 5'b00011, bc, dc);
    check("post_rst.done_cycle", 32'(dc), 32'd6);
    check_result("post_rst", 5'b11001, 1'b0, 1'b0);

    // Signed-overflow vectors (arithmetic checked in every build)
    run_op(5'b01111, 5'b10000, bc, dc);
    check_result("ovf1", 5'b11111, 1'b1, 1'b0);
`ifdef SERIAL_SUB_SIGNED_EN
    check("ovf1.overflow", 32'(overflow), 32'd1);
`endif
    run_op(5'b10000, 5'b00001, bc, dc);
    check_result("ovf2", 5'b01111, 1'b0, 1'b0);
`ifdef SERIAL_SUB_SIGNED_EN
    check("ovf2.overflow", 32'(overflow), 32'd1);
`endif
    run_op(5'b00000, 5'b00000, bc, dc);
    check_result("zero", 5'b00000, 1'b0, 1'b1);
`ifdef SERIAL_SUB_SIGNED_EN
    check("zero.overflow", 32'(overflow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor, the inverse operation of the team's adder datapath. It computes x - y one bit per clock, LSB first, through a single full-subtractor cell. The block latches both operands on a start handshake and returns the difference, the final borrow and an equality flag with a one-cycle done pulse. It sits beside the ALU's equality comparator as the sequential, area-minimal subtract/compare path.

Parameters:
WIDTH, 5, operand and difference width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only in IDLE.
x  input  WIDTH  minuend; sampled on the accepting edge only.
y  input  WIDTH  subtrahend; sampled on the accepting edge only.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
diff  output  WIDTH  x - y modulo 2^WIDTH.
borrow  output  1  final borrow out; 1 when x < y unsigned.
equal  output  1  1 when x == y.
overflow  output  1  present only with SERIAL_SUB_SIGNED_EN.

Behaviour:
- Reset (asynchronous, active-high, one clock; any time, including mid-RUN):
  - state goes to IDLE.
  - busy=0, done=0, diff=0, borrow=0, equal=0, overflow=0.
  - shift registers, bit counter and carry borrow are cleared.
  - The in-flight operation is discarded; no done pulse follows.
- States and transitions:
  - IDLE -> RUN on a clock edge with start=1. That edge loads x and y into shift registers, sets the bit counter to 0 and sets the internal borrow to 0.
  - RUN processes one bit per edge, from bit 0 up to bit WIDTH-1:
    - a = x_sr[0], b = y_sr[0].
    - d = a ^ b ^ bin.
    - bout = (~a & b) | (~(a ^ b) & bin).
    - d shifts into the result register from the MSB side; both operand registers shift right.
  - On the edge that processes bit WIDTH-1: state -> DONE; diff, borrow and equal load together.
    - equal = (result == 0).
  - DONE -> IDLE unconditionally on the next edge.
- Outputs:
  - busy = (state == RUN).
  - done = (state == DONE), exactly one cycle.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+WIDTH. A new start is accepted at edge k+WIDTH+2 at the earliest.
- Handshake:
  - start is ignored in RUN and DONE, with no queuing.
  - Operand changes after acceptance have no effect.
  - start held high continuously restarts an operation each time IDLE is re-entered.
- Result hold: diff, borrow, equal and overflow are registered. They update only on the completion edge and hold between operations, including through the next RUN.
- Arithmetic: unsigned modulo 2^WIDTH. borrow = 1 iff x < y unsigned.
- Boundaries:
  - x = y = 0: diff=0, borrow=0, equal=1.
  - x = 0, y = all-ones: diff=1, borrow=1.

Optional Feature:
SERIAL_SUB_SIGNED_EN:
- Defined:
  - Adds the overflow output.
  - Loaded on the completion edge with (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]), using the latched operand MSBs.
  - Reset value 0; held like diff.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
1. Latency: rst pulse, then x=00001, y=00000, start for 1 cycle -> busy high for 5 cycles; done pulse in cycle 6 after the accepting edge; diff=00001, borrow=0, equal=0.
2. Equality: x=01100, y=01100 -> diff=00000, borrow=0, equal=1. Then x=00001, y=00100 -> diff=11101, borrow=1, equal=0, overflow=0.
3. Ignored inputs: x=10101, y=10100 accepted; start kept high and x=11111 driven during RUN -> diff=00001, borrow=0; the next operation starts only after DONE->IDLE.
4. Reset mid-operation: rst asserted asynchronously at the 3rd RUN cycle -> busy, done and diff go 0 without waiting for a clock edge; no done pulse. Then x=11100, y=00011 -> diff=11001, borrow=0.
5. Signed overflow (SERIAL_SUB_SIGNED_EN): x=01111, y=10000 -> diff=11111, borrow=1, overflow=1. x=10000, y=00001 -> diff=01111, overflow=1. x=00000, y=00000 -> overflow=0, equal=1.
6. Result hold: after case 2 completes, hold start=0 for 10 cycles -> diff, borrow and equal stay unchanged; done stays 0.
